// File: rtl/stream_drain_fifo.sv
// Circular-store FIFO that absorbs a valid-qualified stream and lets a stalling
// consumer drain it first-word-fall-through, reporting occupancy and overflow.
module stream_drain_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready/valid come from registered state only, never from the partner.
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wp;
  logic [ADDR_WIDTH:0]   rp;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic                  full;
  logic                  empty;
  logic                  wr_fire;
  logic                  rd_fire;

  // Wrap bit distinguishes full from empty when the low address bits match.
  assign empty = (wp == rp);
  assign full  = (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]) &&
                 (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign out_data  = mem[rp[ADDR_WIDTH-1:0]];
  assign count     = count_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem[wp[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        wp <= wp + PTR_ONE;
      end
      if (rd_fire) begin
        rp <= rp + PTR_ONE;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_drain_fifo.sv
// Directed bench for stream_drain_fifo: occupancy model plus an expected-word
// queue, checked with immediate assertions between clock edges.
module tb_stream_drain_fifo;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   count;
  logic          overflow;

  stream_drain_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Scoreboard: words expected on out_data, plus the bench's own occupancy model
  logic [DW-1:0] exp_q[$];
  int            m_count = 0;
  logic          m_ovf   = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One normal cycle: drive, check state against the model, clock, update model.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy);
    logic wr;
    logic rd;
    logic [DW-1:0] exp_word;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    wr = iv && (m_count < DEPTH);
    rd = ordy && (m_count > 0);
    check("in_ready",  {31'd0, in_ready},  {31'd0, m_count < DEPTH});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_count > 0});
    check("count",     {29'd0, count},     DW'(m_count));
    check("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
    if (rd) begin
      if (exp_q.size() > 0) begin
        exp_word = exp_q.pop_front();
        check("out_data", out_data, exp_word);
      end else begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end
    end
    @(posedge clk);
    if (wr) exp_q.push_back(id);
    if (iv && !(m_count < DEPTH)) m_ovf = 1'b1;
    m_count = m_count + (wr ? 1 : 0) - (rd ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic reset_cycle(input logic iv, input logic [DW-1:0] id, input logic ordy);
    rst       = 1'b1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(posedge clk);
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hA5A5A5A5;
    out_ready = 1'b1;

    // Reset held two cycles with both sides requesting
    reset_cycle(1'b1, 32'hA5A5A5A5, 1'b1);
    reset_cycle(1'b1, 32'hA5A5A5A5, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_count",     {29'd0, count},     32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_overflow",  {31'd0, overflow},  32'd0);

    // Fill with consumer stalled
    step(1'b1, 32'h11111111, 1'b0);
    step(1'b1, 32'h22222222, 1'b0);
    step(1'b1, 32'h33333333, 1'b0);
    step(1'b1, 32'h44444444, 1'b0);
    #1;
    check("fill_count",    {29'd0, count},    32'd4);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);

    // Overflow while full
    step(1'b1, 32'hDEADBEEF, 1'b0);
    #1;
    check("ovf_flag",  {31'd0, overflow}, 32'd1);
    check("ovf_count", {29'd0, count},    32'd4);
    check("ovf_head",  out_data,          32'h11111111);

    // Drain in order; DEADBEEF must not appear
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_word", out_data, 32'h11111111 * (i + 1));
      step(1'b0, 32'h0, 1'b1);
    end
    #1;
    check("drain_count",     {29'd0, count},     32'd0);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("ovf_sticky",      {31'd0, overflow},  32'd1);

    // Streaming across pointer wrap
    reset_cycle(1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, DW'(i), 1'b1);
      #1;
      check("stream_count_le1", {31'd0, count <= 1}, 32'd1);
      check("stream_head",      out_data,            DW'(i));
      check("stream_overflow",  {31'd0, overflow},   32'd0);
    end
    step(1'b0, 32'h0, 1'b1);
    #1;
    check("stream_empty", {31'd0, out_valid}, 32'd0);

    // Full with simultaneous read: read fires, write dropped
    for (int i = 1; i <= 4; i++) step(1'b1, 32'hA0 + DW'(i), 1'b0);
    step(1'b1, 32'h99, 1'b1);
    #1;
    check("fullrd_count", {29'd0, count},    32'd3);
    check("fullrd_ovf",   {31'd0, overflow}, 32'd1);
    check("fullrd_head",  out_data,          32'hA2);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    #1;
    check("fullrd_empty", {31'd0, out_valid}, 32'd0);

    // Mid-stream reset while writing 0x55
    step(1'b1, 32'h77, 1'b0);
    step(1'b1, 32'h78, 1'b0);
    #1;
    check("mid_count_pre", {29'd0, count}, 32'd2);
    reset_cycle(1'b1, 32'h55, 1'b0);
    in_valid = 1'b0;
    #1;
    check("mid_count",     {29'd0, count},     32'd0);
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_in_ready",  {31'd0, in_ready},  32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

    // Offer on both sides while empty: no bypass, word appears next cycle
    step(1'b1, 32'h66, 1'b1);
    #1;
    check("empty_wr_count", {29'd0, count}, 32'd1);
    check("empty_wr_head",  out_data,       32'h66);
    step(1'b0, 32'h0, 1'b1);
    #1;
    check("final_empty", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
